// File: rtl/interval_timer.sv
// Countdown timer for the traffic-light FSM: loads one of three programmable
// intervals (seconds) and pulses expired once after counting it down on a 1 s tick.
module interval_timer #(
  parameter int         TICK_DIV = 100_000_000,
  parameter logic [3:0] BASE_DEF = 4'd6,
  parameter logic [3:0] EXT_DEF  = 4'd3,
  parameter logic [3:0] YEL_DEF  = 4'd2
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       start_timer,
  input  logic [1:0] interval_address,
  input  logic       prg_sync_in,
  input  logic [1:0] time_param_selector,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  localparam int             DIV_W   = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] divider, divider_d;
  logic [3:0]       remaining_d;
  logic             expired_d;
  logic [3:0]       base_len, ext_len, yel_len;
  logic [3:0]       load_val;
  logic             tick;

  // Programmable interval registers; zero writes are dropped so a load is never 0.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      base_len <= BASE_DEF;
      ext_len  <= EXT_DEF;
      yel_len  <= YEL_DEF;
    end else if (prg_sync_in) begin
      case (time_param_selector)
        2'b00: if (time_value != 4'd0) base_len <= time_value;
        2'b01: if (time_value != 4'd0) ext_len  <= time_value;
        2'b10: if (time_value != 4'd0) yel_len  <= time_value;
        default: begin
          base_len <= BASE_DEF;
          ext_len  <= EXT_DEF;
          yel_len  <= YEL_DEF;
        end
      endcase
    end
  end

  always_comb begin
    case (interval_address)
      2'b01:   load_val = ext_len;
      2'b10:   load_val = yel_len;
      default: load_val = base_len;
    endcase
  end

  assign tick = (state_q == COUNT) && (divider == DIV_MAX);

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= IDLE;
      divider   <= '0;
      remaining <= 4'd0;
      expired   <= 1'b0;
    end else begin
      state_q   <= state_d;
      divider   <= divider_d;
      remaining <= remaining_d;
      expired   <= expired_d;
    end
  end

  // Start has priority over the tick, so a reload on the final tick suppresses expired.
  always_comb begin
    state_d     = state_q;
    divider_d   = '0;
    remaining_d = remaining;
    expired_d   = 1'b0;
    if (start_timer) begin
      state_d     = COUNT;
      remaining_d = load_val;
    end else if (state_q == COUNT) begin
      if (tick) begin
        if (remaining > 4'd1) begin
          remaining_d = remaining - 4'd1;
        end else begin
          remaining_d = 4'd0;
          expired_d   = 1'b1;
          state_d     = IDLE;
        end
      end else begin
        divider_d = divider + 1'b1;
      end
    end else begin
      remaining_d = 4'd0;
    end
  end

  assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICK_DIV=4 and default intervals 6/3/2.
module tb_interval_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       sys_reset_n;
  logic       start_timer;
  logic [1:0] interval_address;
  logic       prg_sync_in;
  logic [1:0] time_param_selector;
  logic [3:0] time_value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  int checks = 0;
  int fails  = 0;

  interval_timer #(.TICK_DIV(TD), .BASE_DEF(4'd6), .EXT_DEF(4'd3), .YEL_DEF(4'd2)) dut (
    .clk                 (clk),
    .sys_reset_n         (sys_reset_n),
    .start_timer         (start_timer),
    .interval_address    (interval_address),
    .prg_sync_in         (prg_sync_in),
    .time_param_selector (time_param_selector),
    .time_value          (time_value),
    .expired             (expired),
    .busy                (busy),
    .remaining           (remaining)
  );

  always #5 clk = ~clk;

  // Start strobe sampled at the next rising edge (E0); returns 1 ns after E0.
  task automatic do_start(input logic [1:0] addr);
    @(negedge clk);
    start_timer      = 1'b1;
    interval_address = addr;
    @(posedge clk);
    #1;
    start_timer = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clk);
    prg_sync_in         = 1'b1;
    time_param_selector = sel;
    time_value          = val;
    @(negedge clk);
    prg_sync_in = 1'b0;
  endtask

  // Counts edges after E0 until expired is seen; -1 when the bound runs out.
  task automatic wait_expire(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk);
      #1;
      if (expired === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    sys_reset_n         = 1'b0;
    start_timer         = 1'b0;
    interval_address    = 2'b00;
    prg_sync_in         = 1'b0;
    time_param_selector = 2'b00;
    time_value          = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (remaining !== 4'd0) begin fails++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    checks++; if (expired !== 1'b0) begin fails++; $display("FAIL reset_expired got=%0b exp=0", expired); end
    @(negedge clk);
    sys_reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_then_start;
    int lat;
    do_start(2'b00);
    checks++; if (remaining !== 4'd6) begin fails++; $display("FAIL start_remaining got=%0d exp=6", remaining); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy got=%0b exp=1", busy); end
    wait_expire(100, lat);
    checks++; if (lat !== 24) begin fails++; $display("FAIL base_latency got=%0d exp=24", lat); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_expire got=%0b exp=0", busy); end
    @(posedge clk);
    #1;
    checks++; if (expired !== 1'b0) begin fails++; $display("FAIL expired_one_cycle got=%0b exp=0", expired); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_program_load;
    int lat;
    do_write(2'b01, 4'd9);
    do_start(2'b01);
    checks++; if (remaining !== 4'd9) begin fails++; $display("FAIL ext_remaining got=%0d exp=9", remaining); end
    wait_expire(100, lat);
    checks++; if (lat !== 36) begin fails++; $display("FAIL ext_latency got=%0d exp=36", lat); end
    do_start(2'b11);
    wait_expire(100, lat);
    checks++; if (lat !== 24) begin fails++; $display("FAIL addr11_latency got=%0d exp=24", lat); end
  endtask

  task automatic test_zero_and_defaults;
    int lat;
    do_write(2'b10, 4'd0);
    do_start(2'b10);
    wait_expire(100, lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL zero_write_latency got=%0d exp=8", lat); end
    do_write(2'b10, 4'd5);
    do_write(2'b11, 4'd7);
    do_start(2'b10);
    wait_expire(100, lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL restore_yel_latency got=%0d exp=8", lat); end
    do_start(2'b01);
    wait_expire(100, lat);
    checks++; if (lat !== 12) begin fails++; $display("FAIL restore_ext_latency got=%0d exp=12", lat); end
  endtask

  task automatic test_restart;
    int lat;
    int late_pulses;
    do_start(2'b00);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin
        checks++; if (remaining !== 4'd5) begin fails++; $display("FAIL decrement_k4 got=%0d exp=5", remaining); end
      end
      if (k == 8) begin
        checks++; if (remaining !== 4'd4) begin fails++; $display("FAIL decrement_k8 got=%0d exp=4", remaining); end
      end
    end
    do_start(2'b10);
    checks++; if (remaining !== 4'd2) begin fails++; $display("FAIL restart_remaining got=%0d exp=2", remaining); end
    wait_expire(100, lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL restart_latency got=%0d exp=8", lat); end
    late_pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (expired === 1'b1) late_pulses++;
    end
    checks++; if (late_pulses !== 0) begin fails++; $display("FAIL restart_stale_expire got=%0d exp=0", late_pulses); end
  endtask

  task automatic test_collisions;
    int lat;
    do_start(2'b00);
    repeat (23) @(posedge clk);
    do_start(2'b10);
    checks++; if (expired !== 1'b0) begin fails++; $display("FAIL collide_expired got=%0b exp=0", expired); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL collide_busy got=%0b exp=1", busy); end
    checks++; if (remaining !== 4'd2) begin fails++; $display("FAIL collide_remaining got=%0d exp=2", remaining); end
    wait_expire(100, lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL collide_latency got=%0d exp=8", lat); end

    @(negedge clk);
    prg_sync_in         = 1'b1;
    time_param_selector = 2'b00;
    time_value          = 4'd2;
    start_timer         = 1'b1;
    interval_address    = 2'b00;
    @(posedge clk);
    #1;
    prg_sync_in = 1'b0;
    start_timer = 1'b0;
    checks++; if (remaining !== 4'd6) begin fails++; $display("FAIL write_load_remaining got=%0d exp=6", remaining); end
    wait_expire(100, lat);
    checks++; if (lat !== 24) begin fails++; $display("FAIL write_load_latency got=%0d exp=24", lat); end
    do_start(2'b00);
    wait_expire(100, lat);
    checks++; if (lat !== 8) begin fails++; $display("FAIL new_base_latency got=%0d exp=8", lat); end
    do_write(2'b11, 4'd0);
  endtask

  task automatic test_async_reset;
    int lat;
    do_write(2'b01, 4'd9);
    do_start(2'b01);
    repeat (11) @(posedge clk);
    #3;
    sys_reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL async_busy got=%0b exp=0", busy); end
    checks++; if (remaining !== 4'd0) begin fails++; $display("FAIL async_remaining got=%0d exp=0", remaining); end
    checks++; if (expired !== 1'b0) begin fails++; $display("FAIL async_expired got=%0b exp=0", expired); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_reset_n = 1'b1;
    do_start(2'b01);
    checks++; if (remaining !== 4'd3) begin fails++; $display("FAIL reverted_ext_remaining got=%0d exp=3", remaining); end
    wait_expire(100, lat);
    checks++; if (lat !== 12) begin fails++; $display("FAIL reverted_ext_latency got=%0d exp=12", lat); end
  endtask

  initial begin
    test_reset;
    test_reset_then_start;
    test_program_load;
    test_zero_and_defaults;
    test_restart;
    test_collisions;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
